// File: rtl/i2s_rx.sv
// I2S stereo receiver: deserialises bit_clk/frame_clk/data (sampled in clk) into left/right samples.
// Optional macro I2S_RX_SYNC_EN inserts a metastability flop ahead of the r1 input stage.
module i2s_rx #(
    parameter int MAX_WORD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          word_length,
    input  logic                bit_clk,
    input  logic                frame_clk,
    input  logic                data,
    output logic [MAX_WORD-1:0] received_left,
    output logic [MAX_WORD-1:0] received_right,
    output logic                valid,
    output logic                frame_error
);
    localparam int CW = $clog2(MAX_WORD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          stage_in_s;
    logic                bclk_r1;
    logic                ws_r1;
    logic                data_r1;
    logic                bclk_r2;
    logic                prev_ws_r;
    logic                rise_s;
    logic                ws_change_s;
    logic [CW-1:0]       new_len_s;
    logic [CW-1:0]       len_r;
    logic [CW-1:0]       count_r;
    logic                count_lt_len_s;
    logic [MAX_WORD-1:0] shreg_r;
    logic [MAX_WORD-1:0] shadow_r;
    logic [MAX_WORD-1:0] cap_val_s;
    logic [MAX_WORD-1:0] left_out_r;
    logic [MAX_WORD-1:0] right_out_r;
    logic                valid_r;
    logic                frame_error_r;
    logic                start_slot_s;
    logic                shift_s;
    logic                left_end_s;
    logic                left_err_s;
    logic                right_err_s;
    logic                done_shift_s;
    logic                done_empty_s;

`ifdef I2S_RX_SYNC_EN
    logic [2:0] meta_r;

    // Metastability flop on the raw asynchronous I2S inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 3'b000;
        end else begin
            meta_r <= {bit_clk, frame_clk, data};
        end
    end

    assign stage_in_s = meta_r;
`else
    assign stage_in_s = {bit_clk, frame_clk, data};
`endif

    // Input staging (r1/r2) and frame_clk value remembered at the last bit_clk rise
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_r1   <= 1'b0;
            ws_r1     <= 1'b0;
            data_r1   <= 1'b0;
            bclk_r2   <= 1'b0;
            prev_ws_r <= 1'b0;
        end else begin
            {bclk_r1, ws_r1, data_r1} <= stage_in_s;
            bclk_r2                   <= bclk_r1;
            if (rise_s) begin
                prev_ws_r <= ws_r1;
            end
        end
    end

    assign rise_s         = bclk_r1 & ~bclk_r2;
    assign ws_change_s    = rise_s & (ws_r1 != prev_ws_r);
    assign new_len_s      = (word_length > 8'(MAX_WORD)) ? CW'(MAX_WORD) : word_length[CW-1:0];
    assign count_lt_len_s = (count_r < len_r);
    assign cap_val_s      = {shreg_r[MAX_WORD-2:0], data_r1};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and slot control strobes; a frame_clk change edge is the delay slot
    always_comb begin
        state_next_s = state_r;
        start_slot_s = 1'b0;
        shift_s      = 1'b0;
        left_end_s   = 1'b0;
        left_err_s   = 1'b0;
        right_err_s  = 1'b0;
        done_shift_s = 1'b0;
        done_empty_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ws_change_s && !ws_r1) begin
                    start_slot_s = 1'b1;
                    state_next_s = LEFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LEFT: begin
                if (ws_change_s) begin
                    left_end_s   = 1'b1;
                    left_err_s   = count_lt_len_s;
                    start_slot_s = 1'b1;
                    if (new_len_s == CW'(0)) begin
                        done_empty_s = 1'b1;
                        state_next_s = RDONE;
                    end else begin
                        state_next_s = RIGHT;
                    end
                end else if (rise_s && count_lt_len_s) begin
                    shift_s = 1'b1;
                end else begin
                    shift_s = 1'b0;
                end
            end
            RIGHT: begin
                if (ws_change_s) begin
                    right_err_s  = count_lt_len_s;
                    start_slot_s = 1'b1;
                    state_next_s = LEFT;
                end else if (rise_s && count_lt_len_s) begin
                    shift_s = 1'b1;
                    if ((count_r + CW'(1)) == len_r) begin
                        done_shift_s = 1'b1;
                        state_next_s = RDONE;
                    end else begin
                        state_next_s = RIGHT;
                    end
                end else begin
                    shift_s = 1'b0;
                end
            end
            RDONE: begin
                if (ws_change_s) begin
                    start_slot_s = 1'b1;
                    state_next_s = LEFT;
                end else begin
                    state_next_s = RDONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Shift register, bit count, left shadow and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r       <= '0;
            shadow_r      <= '0;
            count_r       <= '0;
            len_r         <= '0;
            left_out_r    <= '0;
            right_out_r   <= '0;
            valid_r       <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            valid_r       <= done_shift_s | done_empty_s;
            frame_error_r <= left_err_s | right_err_s;
            if (start_slot_s) begin
                shreg_r <= '0;
                count_r <= '0;
                len_r   <= new_len_s;
            end else if (shift_s) begin
                shreg_r <= cap_val_s;
                count_r <= count_r + CW'(1);
            end
            if (left_end_s) begin
                shadow_r <= shreg_r;
            end
            // A zero-length right slot completes at its delay edge, before the shadow is visible
            if (done_shift_s) begin
                left_out_r  <= shadow_r;
                right_out_r <= cap_val_s;
            end else if (done_empty_s) begin
                left_out_r  <= shreg_r;
                right_out_r <= '0;
            end
        end
    end

    assign received_left  = left_out_r;
    assign received_right = right_out_r;
    assign valid          = valid_r;
    assign frame_error    = frame_error_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: frame-level reference model with randomized slots and lengths.
module tb_i2s_rx;
`ifdef I2S_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  word_length = 8'd0;
    logic        bit_clk = 1'b0;
    logic        frame_clk = 1'b0;
    logic        data = 1'b0;
    logic [15:0] received_left;
    logic [15:0] received_right;
    logic        valid;
    logic        frame_error;

    i2s_rx #(.MAX_WORD(16)) dut (
        .clk(clk),
        .reset(reset),
        .word_length(word_length),
        .bit_clk(bit_clk),
        .frame_clk(frame_clk),
        .data(data),
        .received_left(received_left),
        .received_right(received_right),
        .valid(valid),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    int total = 0;
    int bad = 0;
    int vq_cyc[$];
    int vq_l[$];
    int vq_r[$];
    int eq_cyc[$];
    int exp_l = 0;
    int exp_r = 0;
    int vcount = 0;
    int fecount = 0;
    bit synced = 1'b0;
    bit last_ws = 1'b0;
    bit pend_rerr = 1'b0;
    int h = 2;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation queues filled by the frame model
    always @(negedge clk) begin : compare
        bit ev;
        bit ee;
        if (rst_q) begin
            exp_l = 0;
            exp_r = 0;
        end
        ev = (vq_cyc.size() > 0) && (vq_cyc[0] == cyc);
        ee = (eq_cyc.size() > 0) && (eq_cyc[0] == cyc);
        if (ev) begin
            void'(vq_cyc.pop_front());
            exp_l = vq_l.pop_front();
            exp_r = vq_r.pop_front();
        end
        if (ee) begin
            void'(eq_cyc.pop_front());
        end
        chk("valid", int'(valid), int'(ev));
        chk("frame_error", int'(frame_error), int'(ee));
        chk("received_left", int'(received_left), exp_l);
        chk("received_right", int'(received_right), exp_r);
        if (valid) vcount++;
        if (frame_error) fecount++;
    end

    task automatic period_rise(input bit ws, input bit d, output int rc);
        bit_clk   = 1'b0;
        frame_clk = ws;
        data      = d;
        repeat (h) @(posedge clk);
        #1;
        bit_clk = 1'b1;
        rc = cyc;
    endtask

    task automatic hold_high();
        repeat (h) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit_clk = 1'b0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        synced    = 1'b0;
        last_ws   = 1'b0;
        pend_rerr = 1'b0;
    endtask

    // One slot (delay period + n bits MSB first) with no expectations attached
    task automatic raw_slot(input bit ws, input int word, input int n);
        int rc;
        period_rise(ws, 1'($urandom_range(0, 1)), rc);
        hold_high();
        for (int i = 0; i < n; i++) begin
            period_rise(ws, 1'((word >> (n - 1 - i)) & 1), rc);
            hold_high();
        end
        last_ws = ws;
    endtask

    // Full left+right frame; k/m are the data bits actually carried in each slot
    task automatic send_frame(input int wl, input int lw, input int k, input int rw, input int m);
        int len;
        int lwm;
        int rwm;
        int lv;
        int rv;
        int rc;
        len = (wl > 16) ? 16 : wl;
        lwm = lw & ((1 << k) - 1);
        rwm = rw & ((1 << m) - 1);
        if (len == 0) lv = 0;
        else if (k >= len) lv = lwm >> (k - len);
        else lv = lwm;
        rv = (len > 0 && m >= len) ? (rwm >> (m - len)) : 0;
        word_length = 8'(wl);
        h = $urandom_range(LAT, 4);

        period_rise(1'b0, 1'($urandom_range(0, 1)), rc);
        if (last_ws) begin
            if (synced && pend_rerr) eq_cyc.push_back(rc + LAT);
            synced = 1'b1;
        end
        pend_rerr = 1'b0;
        hold_high();
        for (int i = 0; i < k; i++) begin
            period_rise(1'b0, 1'((lwm >> (k - 1 - i)) & 1), rc);
            hold_high();
        end

        period_rise(1'b1, 1'($urandom_range(0, 1)), rc);
        if (synced) begin
            if (k < len) eq_cyc.push_back(rc + LAT);
            if (len == 0) begin
                vq_cyc.push_back(rc + LAT);
                vq_l.push_back(lv);
                vq_r.push_back(0);
            end
        end
        hold_high();
        for (int i = 0; i < m; i++) begin
            period_rise(1'b1, 1'((rwm >> (m - 1 - i)) & 1), rc);
            if (synced && len > 0 && i == len - 1) begin
                vq_cyc.push_back(rc + LAT);
                vq_l.push_back(lv);
                vq_r.push_back(rv);
            end
            hold_high();
        end
        pend_rerr = synced && (m < len);
        last_ws = 1'b1;
    endtask

    initial begin
        int v0;
        int f0;
        do_reset();
        chk("reset_left", int'(received_left), 0);
        chk("reset_right", int'(received_right), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_ferr", int'(frame_error), 0);

        // Stream joins mid right slot: nothing may be captured yet
        raw_slot(1'b1, 0, 5);
        chk("midright_no_valid", vcount, 0);

        send_frame(4, 7, 4, 13, 4);
        chk("wl4_left", int'(received_left), 32'h0007);
        chk("wl4_right", int'(received_right), 32'h000D);
        chk("wl4_vcount", vcount, 1);
        chk("wl4_ferr", fecount, 0);

        for (int f = 0; f < 3; f++) begin
            send_frame(16, 32'hA5C3, 16, 32'h3C5A, 16);
            chk("wl16_left", int'(received_left), 32'hA5C3);
            chk("wl16_right", int'(received_right), 32'h3C5A);
        end
        chk("wl16_vcount", vcount, 4);

        send_frame(20, 32'hFFFF, 16, 32'h0001, 16);
        chk("clamp_left", int'(received_left), 32'hFFFF);
        chk("clamp_right", int'(received_right), 32'h0001);

        f0 = fecount;
        send_frame(8, 32'h16, 5, 32'h5A, 8);
        chk("shortleft_ferr", fecount, f0 + 1);
        chk("shortleft_left", int'(received_left), 32'h0016);
        chk("shortleft_right", int'(received_right), 32'h005A);

        v0 = vcount;
        send_frame(8, 32'h33, 8, 32'h5, 3);
        chk("shortright_no_valid", vcount, v0);
        chk("shortright_hold_left", int'(received_left), 32'h0016);
        send_frame(8, 32'h81, 8, 32'h42, 8);
        chk("shortright_ferr", fecount, f0 + 2);
        chk("after_short_left", int'(received_left), 32'h0081);
        chk("after_short_right", int'(received_right), 32'h0042);

        send_frame(0, 5, 3, 6, 3);
        chk("wl0_left", int'(received_left), 0);
        chk("wl0_right", int'(received_right), 0);
        chk("wl0_vcount", vcount, v0 + 2);

        for (int f = 0; f < 40; f++) begin
            send_frame(int'($urandom_range(0, 20)), int'($urandom), int'($urandom_range(0, 18)),
                       int'($urandom), int'($urandom_range(0, 18)));
        end

        // Reset in the middle of a left slot carrying 0x0003
        send_frame(8, 32'h11, 8, 32'h22, 8);
        raw_slot(1'b0, 3, 2);
        do_reset();
        chk("midreset_left", int'(received_left), 0);
        chk("midreset_right", int'(received_right), 0);
        v0 = vcount;
        raw_slot(1'b1, 0, 8);
        chk("midreset_no_valid", vcount, v0);
        send_frame(8, 32'h09, 8, 32'h02, 8);
        chk("resume_left", int'(received_left), 32'h0009);
        chk("resume_right", int'(received_right), 32'h0002);
        chk("resume_vcount", vcount, v0 + 1);

        repeat (10) @(posedge clk);
        #1;
        chk("valid_queue_drained", vq_cyc.size(), 0);
        chk("ferr_queue_drained", eq_cyc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
